// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the multi-channel gated frequency meter.
package freq_meter_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Default gate length (1 s at 50 MHz) and the timer width it needs.
    localparam int GATE_CYC_DEF = 50_000_000;
    localparam int GATE_TMR_W   = $clog2(GATE_CYC_DEF);

    // Short-gate divisor used by the optional autorange feature.
    localparam int AR_DIV = 10;

    // Timer width for an arbitrary gate length; the timer only reaches gate_cyc-1.
    function automatic int gate_tmr_w(input int gate_cyc);
        return (gate_cyc > 1) ? $clog2(gate_cyc) : 1;
    endfunction

endpackage

// File: rtl/freq_edge_cnt.sv
// One measurement channel: input synchroniser, rising-edge detector,
// saturating edge counter and overflow flag for the current gate.
module freq_edge_cnt #(
    parameter int CNT_W    = 20,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STG-1:0] sync;
    logic                dly;
    logic                rise;

    // Synchroniser chain followed by one delay flop for edge detection.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STG-2:0], sig};
            dly  <= sync[SYNC_STG-1];
        end
    end

    assign rise = sync[SYNC_STG-1] & ~dly;

    // Saturating counter; the clearing cycle is itself a counting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            ovf_pending <= 1'b0;
        end else if (clr) begin
            cnt         <= {{(CNT_W-1){1'b0}}, rise};
            ovf_pending <= 1'b0;
        end else if (en && rise) begin
            if (cnt == CNT_MAX) ovf_pending <= 1'b1;
            else                cnt         <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency meter with valid/ack result handshake.
// Optional build macro FREQ_AUTORANGE_EN: shortens the gate by AR_DIV after
// a saturating gate and adds the 'range' output (1 = short gate).
module freq_meter_mc
    import freq_meter_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 20,
    parameter int GATE_CYC = 50_000_000,
    parameter int SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_in,
    input  logic                  mode_cont,
    input  logic                  start,
    input  logic                  ack,
    output logic [N_CH*CNT_W-1:0] freq_data,
    output logic [N_CH-1:0]       freq_ovf,
    output logic                  freq_valid,
    output logic                  lost,
    output logic                  busy
`ifdef FREQ_AUTORANGE_EN
    ,
    output logic                  range
`endif
);

    localparam int               TMR_W     = gate_tmr_w(GATE_CYC);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYC - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [TMR_W-1:0]        tmr;
    logic [TMR_W-1:0]        gate_last;
    logic [N_CH*CNT_W-1:0]   cnt_all;
    logic [N_CH-1:0]         ovf_vec;
    logic                    clr;
    logic                    en;

    assign en   = (state == GATE);
    assign clr  = en && (tmr == '0);
    assign busy = en;

    // Per-channel edge counters.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        freq_edge_cnt #(
            .CNT_W    (CNT_W),
            .SYNC_STG (SYNC_STG)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .sig         (sig_in[k]),
            .clr         (clr),
            .en          (en),
            .cnt         (cnt_all[k*CNT_W +: CNT_W]),
            .ovf_pending (ovf_vec[k])
        );
    end

`ifdef FREQ_AUTORANGE_EN
    localparam logic [TMR_W-1:0] SHORT_LAST = TMR_W'(GATE_CYC / AR_DIV - 1);

    logic            short_gate;
    logic [N_CH-1:0] sat_vec;
    logic [N_CH-1:0] low_vec;

    // A channel is "low" when its count is below 2^CNT_W/16, i.e. top four bits clear.
    for (genvar k = 0; k < N_CH; k++) begin : g_rng
        assign sat_vec[k] = &cnt_all[k*CNT_W +: CNT_W];
        assign low_vec[k] = ~|cnt_all[k*CNT_W + CNT_W - 4 +: 4];
    end

    assign gate_last = short_gate ? SHORT_LAST : GATE_LAST;

    // Gate-length selection, decided at the end of every gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_gate <= 1'b0;
        end else if (state == LATCH) begin
            if (!short_gate && |sat_vec)     short_gate <= 1'b1;
            else if (short_gate && &low_vec) short_gate <= 1'b0;
        end
    end
`else
    assign gate_last = GATE_LAST;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic; start and mode_cont only matter in IDLE/LATCH.
    // NOTE: default assigned first so no path through always_comb can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (mode_cont || start) state_nxt = GATE;
            GATE:    if (tmr == gate_last)   state_nxt = LATCH;
            LATCH:   state_nxt = mode_cont ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gate timer: runs 0..gate_last while gating, parked at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                tmr <= '0;
        else if (state == GATE && tmr != gate_last) tmr <= tmr + TMR_W'(1);
        else                                    tmr <= '0;
    end

    // Result publication and valid/ack/lost handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_data  <= '0;
            freq_ovf   <= '0;
            freq_valid <= 1'b0;
            lost       <= 1'b0;
`ifdef FREQ_AUTORANGE_EN
            range      <= 1'b0;
`endif
        end else if (state == LATCH) begin
            freq_data  <= cnt_all;
            freq_ovf   <= ovf_vec;
            freq_valid <= 1'b1;
            if (freq_valid && !ack) lost <= 1'b1;
`ifdef FREQ_AUTORANGE_EN
            range      <= short_gate;
`endif
        end else if (freq_valid && ack) begin
            freq_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Self-checking bench for freq_meter_mc. Input waveforms are square waves
// driven on the falling clock edge; every rising pin edge is logged with the
// index of the rising clock edge that samples it, and expected counts are
// the number of logged edges falling inside each gate window.
module tb_freq_meter_mc;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 7;
    localparam int GATE_CYC = 1000;
    localparam int SYNC_STG = 2;
    localparam int MAXC     = (1 << CNT_W) - 1;
    localparam int G        = GATE_CYC;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       sig_in;
    logic                  mode_cont;
    logic                  start;
    logic                  ack;
    logic [N_CH*CNT_W-1:0] freq_data;
    logic [N_CH-1:0]       freq_ovf;
    logic                  freq_valid;
    logic                  lost;
    logic                  busy;
`ifdef FREQ_AUTORANGE_EN
    logic                  range;
`endif

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int per [N_CH];
    int ph  [N_CH];
    int edges [N_CH][$];

    freq_meter_mc #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .GATE_CYC (GATE_CYC),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .mode_cont  (mode_cont),
        .start      (start),
        .ack        (ack),
        .freq_data  (freq_data),
        .freq_ovf   (freq_ovf),
        .freq_valid (freq_valid),
        .lost       (lost),
        .busy       (busy)
`ifdef FREQ_AUTORANGE_EN
        ,
        .range      (range)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update the square waves.
    // A value driven here is sampled by rising edge number ncyc.
    task automatic tick();
        logic v;
        @(negedge clk);
        ncyc++;
        for (int c = 0; c < N_CH; c++) begin
            if (per[c] < 2) begin
                v = 1'b0;
            end else begin
                ph[c] = (ph[c] + 1) % per[c];
                v = (ph[c] < per[c] / 2);
            end
            if (v && !sig_in[c]) edges[c].push_back(ncyc);
            sig_in[c] = v;
        end
    endtask

    task automatic run_until(input int t);
        while (ncyc < t) tick();
    endtask

    task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
        per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
        for (int c = 0; c < N_CH; c++) ph[c] = 0;
        repeat (10) tick();
    endtask

    // Pulse start for one cycle; s is the clock edge that samples it.
    task automatic start_gate(output int s);
        tick();
        start = 1'b1;
        s = ncyc;
        tick();
        start = 1'b0;
    endtask

    // Raw number of pin edges whose count lands on gate clock edges a..b.
    function automatic int model_cnt(input int c, input int a, input int b);
        int n = 0;
        foreach (edges[c][i])
            if (edges[c][i] >= a - SYNC_STG && edges[c][i] <= b - SYNC_STG) n++;
        return n;
    endfunction

    task automatic check_result(input string tag, input int a, input int b);
        int n;
        logic [N_CH-1:0] eovf;
        for (int c = 0; c < N_CH; c++) begin
            n = model_cnt(c, a, b);
            eovf[c] = (n > MAXC);
            check($sformatf("%s_data_ch%0d", tag, c),
                  64'(freq_data[c*CNT_W +: CNT_W]), 64'(n > MAXC ? MAXC : n));
        end
        check({tag, "_ovf"}, 64'(freq_ovf), 64'(eovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},  64'(freq_data),  64'd0);
        check({tag, "_ovf"},   64'(freq_ovf),   64'd0);
        check({tag, "_valid"}, 64'(freq_valid), 64'd0);
        check({tag, "_lost"},  64'(lost),       64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
    endtask

    initial begin
        int s;
        int d0;
        rst = 1'b1; sig_in = '0; mode_cont = 1'b0; start = 1'b0; ack = 1'b0;
        for (int c = 0; c < N_CH; c++) begin per[c] = 0; ph[c] = 0; end
        #1;
        check_zero("reset");
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Single shot: periods 10 / 25 / static / random.
        set_periods(10, 25, 0, int'($urandom_range(8, 60)));
        start_gate(s);
        run_until(s + 500);
        check("t1_busy_mid", 64'(busy), 64'd1);
        start = 1'b1;            // ignored while gating
        tick();
        start = 1'b0;
        run_until(s + G);
        check("t1_busy_last", 64'(busy), 64'd1);
        tick();
        check("t1_busy_latch", 64'(busy), 64'd0);
        tick();
        check("t1_valid", 64'(freq_valid), 64'd1);
        check("t1_lost", 64'(lost), 64'd0);
        check_result("t1", s + 1, s + G);
        d0 = int'(freq_data[0 +: CNT_W]);
        check("t1_ch0_near_100", 64'(d0 >= 99 && d0 <= 101), 64'd1);
        check("t1_ch1", 64'(freq_data[CNT_W +: CNT_W] >= 39 && freq_data[CNT_W +: CNT_W] <= 41), 64'd1);
        repeat (5) tick();
        check("t1_valid_held", 64'(freq_valid), 64'd1);
        check("t1_idle_busy", 64'(busy), 64'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t1_ack_drop", 64'(freq_valid), 64'd0);

        // Saturation on ch0 (250 edges into a 7-bit counter).
        set_periods(4, int'($urandom_range(20, 60)), int'($urandom_range(20, 60)), 0);
        start_gate(s);
        run_until(s + G + 2);
        check_result("sat", s + 1, s + G);
        check("sat_ch0_max", 64'(freq_data[0 +: CNT_W]), 64'(MAXC));
        check("sat_ovf0", 64'(freq_ovf[0]), 64'd1);

        // Ack coincides with LATCH while the previous result is still pending.
        set_periods(int'($urandom_range(2, 70)), int'($urandom_range(2, 70)),
                    int'($urandom_range(2, 70)), int'($urandom_range(2, 70)));
        start_gate(s);
        run_until(s + G + 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ackl_valid", 64'(freq_valid), 64'd1);
        check("ackl_lost", 64'(lost), 64'd0);
        check_result("ackl", s + 1, s + G);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ackl_drop", 64'(freq_valid), 64'd0);

        // Continuous mode over two gates without ack; cleared during gate 2.
        set_periods(int'($urandom_range(2, 70)), int'($urandom_range(2, 70)),
                    int'($urandom_range(2, 70)), 12);
        tick();
        mode_cont = 1'b1;
        s = ncyc;
        run_until(s + G + 2);
        check("cont1_valid", 64'(freq_valid), 64'd1);
        check("cont1_lost", 64'(lost), 64'd0);
        check("cont1_busy", 64'(busy), 64'd1);
        check_result("cont1", s + 1, s + G);
        run_until(s + G + 50);
        mode_cont = 1'b0;
        run_until(s + 2 * G + 3);
        check("cont2_lost", 64'(lost), 64'd1);
        check("cont2_valid", 64'(freq_valid), 64'd1);
        check_result("cont2", s + G + 2, s + 2 * G + 1);
        repeat (10) tick();
        check("cont2_idle", 64'(busy), 64'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("cont2_ack_drop", 64'(freq_valid), 64'd0);

        // Randomised single-shot gates.
        for (int i = 0; i < 3; i++) begin
            set_periods(int'($urandom_range(0, 80)), int'($urandom_range(2, 80)),
                        int'($urandom_range(2, 8)), int'($urandom_range(0, 80)));
            start_gate(s);
            run_until(s + G + 2);
            check_result($sformatf("rnd%0d", i), s + 1, s + G);
            check($sformatf("rnd%0d_lost_sticky", i), 64'(lost), 64'd1);
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end

        // Reset in the middle of a gate, then a clean measurement.
        set_periods(10, 25, 0, int'($urandom_range(8, 60)));
        start_gate(s);
        run_until(s + 500);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        start_gate(s);
        run_until(s + G + 2);
        check("post_rst_valid", 64'(freq_valid), 64'd1);
        check_result("post_rst", s + 1, s + G);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
